// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM with one shared period counter.
// Each channel has a shadow duty register, loaded through a valid/ready write port.
// A commit moves every shadow (and the period) into the active set at the next period
// boundary, so a period is never cut short or stretched.
// Build option: define PWM_CENTER_EN for the center-aligned (up/down) counter.
// Without it the counter is an edge-aligned sawtooth. The ports are the same in both builds.
module pwm_multi #(
   parameter  int WIDTH    = 16,
   parameter  int CHANNELS = 4,
   localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [CW-1:0]       wr_chan,
   input  logic [WIDTH-1:0]    wr_duty,
   input  logic [WIDTH-1:0]    period,
   input  logic                commit,
   output logic                pending,
   output logic                period_start,
   output logic [CHANNELS-1:0] pwm_out
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] cnt_reg;
   logic [WIDTH-1:0] cnt_next;
   logic             dir_down_reg;
   logic             dir_down_next;
   logic [WIDTH-1:0] per_act_reg;
   logic [WIDTH-1:0] per_shd_reg;
   logic             pending_reg;
   logic             period_start_reg;
   logic             boundary;
   logic             wr_fire;
   logic             commit_fire;
   logic             transfer;

   // The shadows stay frozen while a commit is outstanding.
   // This is why a write is refused while pending is high.
   assign wr_ready     = !pending_reg;
   assign wr_fire      = wr_valid && !pending_reg;
   assign commit_fire  = commit && !pending_reg;
   assign transfer     = boundary && pending_reg;
   assign pending      = pending_reg;
   assign period_start = period_start_reg;

   // Find the boundary cycle and the next counter value.
   // While disabled, every cycle counts as a boundary.
   always_comb begin
      boundary      = 1'b0;
      cnt_next      = cnt_reg;
      dir_down_next = dir_down_reg;
      if (!enable) begin
         boundary      = 1'b1;
         cnt_next      = '0;
         dir_down_next = 1'b0;
      end else begin
`ifdef PWM_CENTER_EN
         // Up 0..P, then down P-1..1.
         // For P=1 the top value 1 is also the last value before wrapping to 0.
         if (per_act_reg == '0) begin
            boundary = 1'b1;
         end else if (dir_down_reg) begin
            boundary = (cnt_reg <= ONE);
         end else begin
            boundary = (per_act_reg == ONE) && (cnt_reg >= per_act_reg);
         end
         if (boundary) begin
            cnt_next      = '0;
            dir_down_next = 1'b0;
         end else if (dir_down_reg) begin
            cnt_next = cnt_reg - ONE;
         end else if (cnt_reg >= per_act_reg) begin
            cnt_next      = cnt_reg - ONE;
            dir_down_next = 1'b1;
         end else begin
            cnt_next = cnt_reg + ONE;
         end
`else
         boundary = (cnt_reg >= per_act_reg);
         cnt_next = boundary ? '0 : cnt_reg + ONE;
`endif
      end
   end

   // Hold the counter, the period registers and the commit handshake state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg          <= '0;
         dir_down_reg     <= 1'b0;
         per_act_reg      <= '1;
         per_shd_reg      <= '1;
         pending_reg      <= 1'b0;
         period_start_reg <= 1'b0;
      end else begin
         cnt_reg          <= cnt_next;
         dir_down_reg     <= dir_down_next;
         period_start_reg <= enable && (cnt_reg == '0);
         if (commit_fire) begin
            pending_reg <= 1'b1;
            per_shd_reg <= period;
         end
         if (transfer) begin
            pending_reg <= 1'b0;
            per_act_reg <= per_shd_reg;
         end
      end
   end

   // Per-channel duty registers and compare.
   // A write to a channel number that does not exist matches no gi, so it is dropped.
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [WIDTH-1:0] duty_shd_reg;
      logic [WIDTH-1:0] duty_act_reg;
      logic             pwm_reg;

      // Load the shadow on a write, move it to active on a transfer, then compare against the counter.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            duty_shd_reg <= '0;
            duty_act_reg <= '0;
            pwm_reg      <= 1'b0;
         end else begin
            if (wr_fire && (wr_chan == CW'(gi))) begin
               duty_shd_reg <= wr_duty;
            end
            if (transfer) begin
               duty_act_reg <= duty_shd_reg;
            end
            pwm_reg <= enable && (cnt_reg < duty_act_reg);
         end
      end

      assign pwm_out[gi] = pwm_reg;
   end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi (WIDTH=16, CHANNELS=4).
// The expected per-period high counts and period lengths come from closed-form formulas.
// There is one formula set for each counter mode.
module tb_pwm_multi;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [1:0]  wr_chan = '0;
   logic [15:0] wr_duty = '0;
   logic [15:0] period = '0;
   logic        commit = 1'b0;
   logic        pending;
   logic        period_start;
   logic [3:0]  pwm_out;

   int n_checks = 0;
   int n_fail = 0;
   int hi [4];
   int ps_cnt;

   pwm_multi #(.WIDTH(16), .CHANNELS(4)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_chan(wr_chan), .wr_duty(wr_duty),
      .period(period), .commit(commit), .pending(pending),
      .period_start(period_start), .pwm_out(pwm_out)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   function automatic int exp_per(input int p);
`ifdef PWM_CENTER_EN
      return (p == 0) ? 1 : 2 * p;
`else
      return p + 1;
`endif
   endfunction

   function automatic int exp_hi(input int d, input int p);
      if (d == 0) return 0;
      if (p == 0) return 1;
`ifdef PWM_CENTER_EN
      return (d > p) ? 2 * p : 2 * d - 1;
`else
      return (d > p) ? p + 1 : d;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
      $display("check %-22s observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic write(input logic [1:0] ch, input logic [15:0] d);
      chk("wr_ready_before_write", wr_ready, 1);
      wr_valid = 1'b1;
      wr_chan  = ch;
      wr_duty  = d;
      step();
      wr_valid = 1'b0;
   endtask

   task automatic do_commit(input logic [15:0] p);
      period = p;
      commit = 1'b1;
      step();
      commit = 1'b0;
      chk("pending_after_commit", pending, 1);
   endtask

   task automatic wait_ps();
      int k = 0;
      while (period_start !== 1'b1 && k < 200) begin
         step();
         k++;
      end
      chk("period_start_seen", period_start, 1);
   endtask

   task automatic measure(input int len);
      wait_ps();
      for (int i = 0; i < 4; i++) hi[i] = 0;
      ps_cnt = 0;
      for (int k = 0; k < len; k++) begin
         for (int i = 0; i < 4; i++) hi[i] += int'(pwm_out[i]);
         ps_cnt += int'(period_start);
         step();
      end
   endtask

   initial begin
      int k;
      int per9;
      per9 = exp_per(9);

      // Reset state.
      step();
      step();
      chk("rst_pending", pending, 0);
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_pwm_out", pwm_out, 0);
      chk("rst_period_start", period_start, 0);
      rst_n = 1'b1;
      step();

      // Test 1: ch0=0x4000 with P=0xFFFF. The commit happens while disabled, so it transfers at once.
      write(2'd0, 16'h4000);
      do_commit(16'hFFFF);
      step();
      chk("t1_pending_clear", pending, 0);
      chk("t1_pwm_before", pwm_out, 0);
`ifndef PWM_CENTER_EN
      enable = 1'b1;
      measure(65536);
      chk("t1_ch0_high", hi[0], 16384);
      chk("t1_ch1_high", hi[1], 0);
      chk("t1_ch3_high", hi[3], 0);
      chk("t1_ps_count", ps_cnt, 1);
      enable = 1'b0;
      step();
`else
      // Center mode with P=4 and duty 2: one period reflects counter 0,1,2,3,4,3,2,1.
      write(2'd3, 16'd2);
      do_commit(16'd4);
      step();
      enable = 1'b1;
      wait_ps();
      for (int j = 0; j < 16; j++) begin
         chk("c_pwm_ch3", pwm_out[3], ((j % 8) == 0 || (j % 8) == 1 || (j % 8) == 7) ? 1 : 0);
         chk("c_period_start", period_start, ((j % 8) == 0) ? 1 : 0);
         step();
      end
      enable = 1'b0;
      step();
`endif

      // Test 2: P=9 with ch1=3, ch2=10 (above P) and ch3=0.
      write(2'd1, 16'd3);
      write(2'd2, 16'd10);
      write(2'd3, 16'd0);
      do_commit(16'd9);
      step();
      chk("t2_pending_clear", pending, 0);
      enable = 1'b1;
      measure(2 * per9);
      chk("t2_ch0_high", hi[0], 2 * exp_hi(16'h4000, 9));
      chk("t2_ch1_high", hi[1], 2 * exp_hi(3, 9));
      chk("t2_ch2_high", hi[2], 2 * exp_hi(10, 9));
      chk("t2_ch3_high", hi[3], 0);
      chk("t2_ps_count", ps_cnt, 2);

      // A write while a commit is pending must stall until the transfer.
      do_commit(16'd9);
      wr_valid = 1'b1;
      wr_chan  = 2'd1;
      wr_duty  = 16'd7;
      chk("t2_stalled", wr_ready, 0);
      k = 0;
      while (wr_ready !== 1'b1 && k < 40) begin
         step();
         k++;
      end
      chk("t2_stall_release", wr_ready, 1);
      chk("t2_pending_fell", pending, 0);
      step();
      wr_valid = 1'b0;
      measure(per9);
      chk("t2_old_duty", hi[1], exp_hi(3, 9));
      do_commit(16'd9);
      k = 0;
      while (pending === 1'b1 && k < 40) begin
         step();
         k++;
      end
      chk("t2_pending_timeout", pending, 0);
      measure(per9);
      chk("t2_new_duty", hi[1], exp_hi(7, 9));

      // Test 3: a commit issued exactly on a boundary cycle waits for the following boundary.
      wait_ps();
      write(2'd1, 16'd5);
      for (int j = 0; j < per9 - 3; j++) step();
      period = 16'd9;
      commit = 1'b1;
      step();
      commit = 1'b0;
      chk("t3_pending_set", pending, 1);
      measure(per9);
      chk("t3_no_change", hi[1], exp_hi(7, 9));
      chk("t3_ps_count", ps_cnt, 1);
      chk("t3_pending_done", pending, 0);
      measure(per9);
      chk("t3_new_duty", hi[1], exp_hi(5, 9));
      chk("t3_ch2_high", hi[2], exp_hi(10, 9));

      // Test 4: dropping enable with a commit pending completes the transfer on the next cycle.
      write(2'd1, 16'd2);
      do_commit(16'd9);
      enable = 1'b0;
      step();
      chk("t4_pending_clear", pending, 0);
      chk("t4_pwm_low", pwm_out, 0);
      step();
      chk("t4_pwm_low2", pwm_out, 0);
      chk("t4_ps_low", period_start, 0);
      enable = 1'b1;
      step();
      chk("t4_start_ps", period_start, 1);
      chk("t4_start_ch1", pwm_out[1], 1);
      measure(per9);
      chk("t4_ch1_high", hi[1], exp_hi(2, 9));
      chk("t4_ch0_high", hi[0], exp_hi(16'h4000, 9));
      chk("t4_ps_count", ps_cnt, 1);

      // Test 5: with P=0 every cycle is a boundary and each output is high exactly when its duty is nonzero.
      enable = 1'b0;
      do_commit(16'd0);
      step();
      enable = 1'b1;
      measure(5);
      chk("t5_ch0_high", hi[0], 5);
      chk("t5_ch1_high", hi[1], 5);
      chk("t5_ch3_high", hi[3], 0);
      chk("t5_ps_count", ps_cnt, 5);

      // Test 6: reset in mid-operation discards the pending commit and the shadow contents.
      write(2'd1, 16'd9);
      do_commit(16'd9);
      chk("t6_pwm_before_rst", pwm_out[0], 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_pending", pending, 0);
      chk("t6_rst_pwm", pwm_out, 0);
      chk("t6_rst_wr_ready", wr_ready, 1);
      step();
      rst_n  = 1'b1;
      enable = 1'b0;
      step();
      do_commit(16'd9);
      step();
      enable = 1'b1;
      measure(per9);
      chk("t6_ch0_high", hi[0], 0);
      chk("t6_ch1_high", hi[1], 0);
      chk("t6_ps_count", ps_cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
